fp32_mul_result_stage: RTL and testbench

- Registered downstream stage for the combinational fp32 multiplier.
- Captures each multiplier result together with its two operands through a valid/ready handshake.
- Classifies the result and keeps sticky IEEE-754 exception flags and saturating event counters.
- Buffers results in a small FIFO so the consumer (adder/accumulator or host interface) can apply backpressure.

---
 rtl/fp32_mul_result_stage.sv | 137 +++++++++++++
 tb/tb_fp32_mul_result_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_result_stage.sv
// Registered result stage for the fp32 multiplier: classifies each product, keeps sticky flags and counters.
// One cycle from push to out_valid; in_ready falls only from registered occupancy, with no bypass when full.
module fp32_mul_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [31:0]                in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_class,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_flags,
  output logic                       flag_invalid,
  output logic                       flag_overflow,
  output logic                       flag_underflow,
  output logic [CNT_W-1:0]           cnt_total,
  output logic [CNT_W-1:0]           cnt_exc
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] C_NORM = 3'd0;
  localparam logic [2:0] C_ZERO = 3'd1;
  localparam logic [2:0] C_DEN  = 3'd2;
  localparam logic [2:0] C_INF  = 3'd3;
  localparam logic [2:0] C_NAN  = 3'd4;

  function automatic logic [2:0] classify(input logic [31:0] v);
    logic [2:0] c;
    c = C_NORM;
    if (v[30:23] == 8'hFF) c = (v[22:0] != 23'd0) ? C_NAN : C_INF;
    else if (v[30:23] == 8'h00) c = (v[22:0] != 23'd0) ? C_DEN : C_ZERO;
    return c;
  endfunction

  logic [34:0]      mem_q [DEPTH];
  logic [34:0]      last_q, last_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] tot_q, tot_d, exc_q, exc_d;
  logic [CNT_W-1:0] tot_base, exc_base;

  logic       push, pop;
  logic [2:0] res_cls, a_cls, b_cls;
  logic       inv_c, ovf_c, unf_c, exc_c;
  logic [34:0] head;

  assign in_ready  = (level_q < LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  // When empty the outputs show the most recently popped entry, not stale storage.
  assign out_result = out_valid ? head[34:3] : last_q[34:3];
  assign out_class  = out_valid ? head[2:0]  : last_q[2:0];
  assign level          = level_q;
  assign flag_invalid   = inv_q;
  assign flag_overflow  = ovf_q;
  assign flag_underflow = unf_q;
  assign cnt_total      = tot_q;
  assign cnt_exc        = exc_q;

  always_comb begin
    res_cls = classify(in_result);
    a_cls   = classify(in_a);
    b_cls   = classify(in_b);
    inv_c   = (res_cls == C_NAN);
    ovf_c   = (res_cls == C_INF) &&
              (a_cls != C_INF) && (a_cls != C_NAN) &&
              (b_cls != C_INF) && (b_cls != C_NAN);
    unf_c   = ((res_cls == C_ZERO) || (res_cls == C_DEN)) &&
              (a_cls != C_ZERO) && (a_cls != C_DEN) &&
              (b_cls != C_ZERO) && (b_cls != C_DEN);
    exc_c   = inv_c | ovf_c | unf_c;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = head;
    end
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // Clear first, then apply this cycle's set/increment so a same-cycle event survives.
    inv_d    = (clr_flags ? 1'b0 : inv_q) | (push & inv_c);
    ovf_d    = (clr_flags ? 1'b0 : ovf_q) | (push & ovf_c);
    unf_d    = (clr_flags ? 1'b0 : unf_q) | (push & unf_c);
    tot_base = clr_flags ? '0 : tot_q;
    exc_base = clr_flags ? '0 : exc_q;
    tot_d    = (push && (tot_base != '1)) ? tot_base + CNT_W'(1) : tot_base;
    exc_d    = (push && exc_c && (exc_base != '1)) ? exc_base + CNT_W'(1) : exc_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      tot_q    <= '0;
      exc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      tot_q    <= tot_d;
      exc_q    <= exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_result, res_cls};
  end
endmodule

// File: tb/tb_fp32_mul_result_stage.sv
// Directed and randomized bench for fp32_mul_result_stage against a queue-based reference model.
module tb_fp32_mul_result_stage;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, clr_flags;
  logic [31:0] in_a, in_b, in_result, out_result;
  logic [2:0] out_class;
  logic [$clog2(DEPTH):0] level;
  logic flag_invalid, flag_overflow, flag_underflow;
  logic [CNT_W-1:0] cnt_total, cnt_exc;

  fp32_mul_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_class(out_class), .level(level),
    .clr_flags(clr_flags), .flag_invalid(flag_invalid),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .cnt_total(cnt_total), .cnt_exc(cnt_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic [2:0] c; } ent_t;
  ent_t mq[$];
  ent_t last_e;
  logic m_inv, m_ovf, m_unf;
  int   m_tot, m_exc;
  int   errors = 0;
  int   checks = 0;

  // Class from exponent/fraction arithmetic: 0 normal, 1 zero, 2 denormal, 3 inf, 4 NaN.
  function automatic int fp_class(input logic [31:0] v);
    int e, f;
    e = int'((v >> 23) & 32'hFF);
    f = int'(v % 32'h0080_0000);
    if (e == 255) return (f != 0) ? 4 : 3;
    if (e == 0)   return (f != 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] s;
    s = $urandom_range(0, 1) << 31;
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return s;
      2: return s | $urandom_range(1, 32'h007F_FFFF);
      3: return s | 32'h7F80_0000;
      4: return s | 32'h7F80_0000 | $urandom_range(1, 32'h007F_FFFF);
      default: return s | ($urandom_range(1, 254) << 23) | $urandom_range(0, 32'h007F_FFFF);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_e.r = 32'd0;
    last_e.c = 3'd0;
    m_inv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_tot = 0; m_exc = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_result", out_result, (mq.size() > 0) ? mq[0].r : last_e.r);
    chk("out_class", 32'(out_class), 32'((mq.size() > 0) ? mq[0].c : last_e.c));
    chk("level", 32'(level), 32'(mq.size()));
    chk("flag_invalid", 32'(flag_invalid), 32'(m_inv));
    chk("flag_overflow", 32'(flag_overflow), 32'(m_ovf));
    chk("flag_underflow", 32'(flag_underflow), 32'(m_unf));
    chk("cnt_total", 32'(cnt_total), 32'(m_tot));
    chk("cnt_exc", 32'(cnt_exc), 32'(m_exc));
  endtask

  // One clock: drive, check pre-edge view, clock, then update the model.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic ordy, input logic clr);
    bit mpush, mpop, inv, ovf, unf;
    int rc, ac, bc;
    ent_t e;
    in_valid = v; in_a = a; in_b = b; in_result = r; out_ready = ordy; clr_flags = clr;
    mpush = v && (mq.size() < DEPTH);
    mpop  = ordy && (mq.size() > 0);
    #1;
    check_outputs();
    rc = fp_class(r); ac = fp_class(a); bc = fp_class(b);
    inv = (rc == 4);
    ovf = (rc == 3) && (ac < 3) && (bc < 3);
    unf = (rc == 1 || rc == 2) && !(ac == 1 || ac == 2) && !(bc == 1 || bc == 2);
    @(posedge clk);
    #1;
    if (mpop) last_e = mq.pop_front();
    if (mpush) begin
      e.r = r; e.c = 3'(rc);
      mq.push_back(e);
    end
    if (clr) begin m_inv = 0; m_ovf = 0; m_unf = 0; m_tot = 0; m_exc = 0; end
    if (mpush) begin
      m_inv |= inv; m_ovf |= ovf; m_unf |= unf;
      if (m_tot < SAT) m_tot++;
      if ((inv || ovf || unf) && m_exc < SAT) m_exc++;
    end
    in_valid = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    in_a = '0; in_b = '0; in_result = '0;
    model_reset();
    #1;
    check_outputs();
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic product 2*3=6.
    cycle(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 0);
    chk("t1_out_result", out_result, 32'h40C0_0000);
    chk("t1_cnt_total", 32'(cnt_total), 32'd1);
    cycle(0, 0, 0, 0, 1, 0);

    // NaN result, then clear.
    cycle(1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FFF_FFFF, 1, 0);
    chk("t2_out_class", 32'(out_class), 32'd4);
    chk("t2_flag_invalid", 32'(flag_invalid), 32'd1);
    chk("t2_cnt_exc", 32'(cnt_exc), 32'd1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("t2_clr_invalid", 32'(flag_invalid), 32'd0);
    chk("t2_clr_total", 32'(cnt_total), 32'd0);

    // Overflow then underflow.
    cycle(1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1, 0);
    chk("t3_out_class", 32'(out_class), 32'd3);
    chk("t3_flag_overflow", 32'(flag_overflow), 32'd1);
    cycle(1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1, 0);
    chk("t3_out_class_zero", 32'(out_class), 32'd1);
    chk("t3_flag_underflow", 32'(flag_underflow), 32'd1);
    cycle(0, 0, 0, 0, 1, 0);

    // Fill with backpressure: fifth push must be refused.
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000 + i, 0, 0);
    chk("t4_level_full", 32'(level), 32'd4);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    cycle(1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0010, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);

    // Concurrent push/pop at level 2 across pointer wrap.
    cycle(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 0);
    cycle(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0001, 0, 0);
    for (int i = 0; i < 6; i++)
      cycle(1, 32'h4000_0000, 32'h4000_0000, 32'h4100_0000 + i, 1, 0);
    chk("t5_level", 32'(level), 32'd2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);

    // Clear and push in the same cycle: set and increment win.
    cycle(1, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1, 1);
    chk("t6_clr_push_total", 32'(cnt_total), 32'd1);
    chk("t6_clr_push_inv", 32'(flag_invalid), 32'd1);

    // Randomized phase; small counters reach saturation.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_val(), rnd_val(), rnd_val(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    for (int i = 0; i < 25; i++)
      cycle(1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 1, 0);
    chk("t7_cnt_total_sat", 32'(cnt_total), SAT);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h4000_0000, 32'h4000_0000, 32'h4200_0000 + i, 0, 0);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t8_rst_level", 32'(level), 32'd0);
    chk("t8_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t8_rst_cnt_total", 32'(cnt_total), 32'd0);
    check_outputs();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 0);
    chk("t8_post_rst_result", out_result, 32'h40C0_0000);
    cycle(0, 0, 0, 0, 1, 0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
